// File: rtl/jt49_mix_pkg.sv
// jt49_mix_pkg: shared FSM states and datapath constants for the PSG mixer
package jt49_mix_pkg;
  typedef enum logic [2:0] {IDLE, MA, MB, MC, DC, OUT} state_t;
  localparam int ACCW = 14;
  localparam int OUTW = 16;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;
endpackage

// File: rtl/jt49_dcblock.sv
// jt49_dcblock: leaky-integrator DC tracker, DC-removed difference and 16-bit saturation
module jt49_dcblock
  import jt49_mix_pkg::*;
#(
  parameter int DCSHIFT  = 8,
  parameter int OUTSHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            dc_en_i,
  input  logic [ACCW-1:0] acc_i,
  output logic [OUTW-1:0] sat_o
`ifdef JT49_MIX_OVF_EN
  ,
  output logic            clip_o
`endif
);
  localparam int AVGW = ACCW + DCSHIFT;
  logic [AVGW-1:0] avg_q, avg_d;
  logic signed [ACCW:0] diff_q, diff_d;
  logic [ACCW-1:0] mean;
  logic signed [31:0] sh;
  always_comb begin
    mean   = avg_q[AVGW-1:DCSHIFT];
    diff_d = dc_en_i ? $signed({1'b0, acc_i}) - $signed({1'b0, mean}) : $signed({1'b0, acc_i});
    avg_d  = dc_en_i ? avg_q + AVGW'(acc_i) - AVGW'(mean) : avg_q;
    sh     = 32'(diff_q) <<< OUTSHIFT;
    sat_o  = sh > SAT_MAX ? OUTW'(SAT_MAX) : sh < SAT_MIN ? OUTW'(SAT_MIN) : sh[OUTW-1:0];
  end
`ifdef JT49_MIX_OVF_EN
  assign clip_o = sh > SAT_MAX || sh < SAT_MIN;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      avg_q  <= '0;
      diff_q <= '0;
    end else if (en_i) begin
      avg_q  <= avg_d;
      diff_q <= diff_d;
    end
endmodule

// File: rtl/jt49_mixdc.sv
// jt49_mixdc: serial gain MAC, optional DC removal and PCM output; JT49_MIX_OVF_EN adds sticky ovf/ovf_clr
module jt49_mixdc
  import jt49_mix_pkg::*;
#(
  parameter int DCSHIFT  = 8,
  parameter int OUTSHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        sample,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [7:0]  C,
  input  logic [3:0]  gain_a,
  input  logic [3:0]  gain_b,
  input  logic [3:0]  gain_c,
  input  logic        dc_en,
  output logic signed [15:0] snd,
  output logic        snd_valid
`ifdef JT49_MIX_OVF_EN
  ,
  input  logic        ovf_clr,
  output logic        ovf
`endif
);
  state_t state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [7:0] a_q, b_q, c_q, lvl;
  logic [3:0] ga_q, gb_q, gc_q, g;
  logic [11:0] prod;
  logic dcen_q, cap, valid_q, valid_d;
  logic [OUTW-1:0] snd_q, snd_d, sat;
`ifdef JT49_MIX_OVF_EN
  logic clip, ovf_q, ovf_d;
`endif
  jt49_dcblock #(.DCSHIFT(DCSHIFT), .OUTSHIFT(OUTSHIFT)) u_dc (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q == DC),
    .dc_en_i (dcen_q),
    .acc_i   (acc_q),
    .sat_o   (sat)
`ifdef JT49_MIX_OVF_EN
    ,
    .clip_o  (clip)
`endif
  );
  // one shared multiplier, channel picked by the MAC state
  always_comb begin
    cap     = state_q == IDLE && sample && cen;
    lvl     = state_q == MA ? a_q : state_q == MB ? b_q : c_q;
    g       = state_q == MA ? ga_q : state_q == MB ? gb_q : gc_q;
    prod    = {4'b0, lvl} * {8'b0, g};
    state_d = state_q;
    acc_d   = acc_q;
    snd_d   = snd_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (cap) begin
        state_d = MA;
        acc_d   = '0;
      end
      MA: begin
        state_d = MB;
        acc_d   = acc_q + {2'b0, prod};
      end
      MB: begin
        state_d = MC;
        acc_d   = acc_q + {2'b0, prod};
      end
      MC: begin
        state_d = DC;
        acc_d   = acc_q + {2'b0, prod};
      end
      DC: state_d = OUT;
      OUT: begin
        state_d = IDLE;
        valid_d = 1'b1;
        snd_d   = dcen_q ? sat : {1'b0, acc_q, 1'b0};
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      snd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      snd_q   <= snd_d;
      valid_q <= valid_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {a_q, b_q, c_q} <= '0;
      {ga_q, gb_q, gc_q} <= '0;
      dcen_q <= 1'b0;
    end else if (cap) begin
      {a_q, b_q, c_q} <= {A, B, C};
      {ga_q, gb_q, gc_q} <= {gain_a, gain_b, gain_c};
      dcen_q <= dc_en;
    end
`ifdef JT49_MIX_OVF_EN
  // set has priority over a simultaneous clear
  always_comb ovf_d = (state_q == OUT && dcen_q && clip) || (sample && cen && state_q != IDLE) ? 1'b1 :
                      ovf_clr ? 1'b0 : ovf_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  assign ovf = ovf_q;
`endif
  assign snd = snd_q;
  assign snd_valid = valid_q;
endmodule

// File: tb/tb_jt49_mixdc.sv
// tb_jt49_mixdc: directed vectors against an arithmetic per-sample model of jt49_mixdc
module tb_jt49_mixdc;
  localparam int DCS = 8;
  localparam int OSH = 2;
  logic clk = 0, rst = 1, cen = 0, sample = 0, dc_en = 0;
  logic [7:0] A = 0, B = 0, C = 0;
  logic [3:0] ga = 0, gb = 0, gc = 0;
  logic signed [15:0] snd;
  logic snd_valid;
  int checks = 0, errors = 0;
`ifdef JT49_MIX_OVF_EN
  logic ovf, ovf_clr = 0, m_ovf;
`endif
  jt49_mixdc #(.DCSHIFT(DCS), .OUTSHIFT(OSH)) dut (
    .clk(clk), .rst(rst), .cen(cen), .sample(sample),
    .A(A), .B(B), .C(C), .gain_a(ga), .gain_b(gb), .gain_c(gc),
    .dc_en(dc_en), .snd(snd), .snd_valid(snd_valid)
`ifdef JT49_MIX_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;

  int ecount, due, m_avg, p_snd, p_avg;
  bit pend, p_clip, m_valid;
  logic [15:0] m_snd;
  // per-sample model: whole result computed at capture, released 5 edges later
  always @(posedge clk or posedge rst) begin
    int e, acc, mean, v, na;
    bit set, cl;
    if (rst) begin
      ecount <= 0; pend <= 0; m_valid <= 0; m_snd <= 0; m_avg <= 0;
`ifdef JT49_MIX_OVF_EN
      m_ovf <= 0;
`endif
    end else begin
      e = ecount + 1;
      set = 0;
      ecount <= e;
      m_valid <= pend && e == due;
      if (pend && e == due) begin
        m_snd <= p_snd[15:0];
        pend <= 0;
        set = p_clip;
      end
      if (pend && e == due - 1) m_avg <= p_avg;
      if (sample && cen) begin
        if (pend) set = 1;
        else begin
          acc = A * ga + B * gb + C * gc;
          cl = 0;
          if (dc_en) begin
            mean = m_avg >>> DCS;
            na = m_avg + acc - mean;
            v = (acc - mean) * (1 << OSH);
            cl = v > 32767 || v < -32768;
            v = v > 32767 ? 32767 : v < -32768 ? -32768 : v;
          end else begin
            na = m_avg;
            v = acc * 2;
          end
          pend <= 1; due <= e + 5; p_snd <= v; p_avg <= na; p_clip <= cl;
        end
      end
`ifdef JT49_MIX_OVF_EN
      m_ovf <= set ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
`else
      if (set) p_clip <= p_clip;
`endif
    end
  end

  always @(negedge clk) if (!rst) begin
    checks++;
    if (snd_valid !== m_valid) begin errors++; $display("FAIL valid t=%0t got %b want %b", $time, snd_valid, m_valid); end
    checks++;
    if (snd !== m_snd) begin errors++; $display("FAIL snd t=%0t got %0d want %0d", $time, snd, $signed(m_snd)); end
`ifdef JT49_MIX_OVF_EN
    checks++;
    if (ovf !== m_ovf) begin errors++; $display("FAIL ovf t=%0t got %b want %b", $time, ovf, m_ovf); end
`endif
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %0d want %0d", name, $signed(act), $signed(exp)); end
  endtask

  task automatic pulse(input int a, b, c, g1, g2, g3, input bit dc, input bit ce);
    @(negedge clk);
    A = 8'(a); B = 8'(b); C = 8'(c); ga = 4'(g1); gb = 4'(g2); gc = 4'(g3);
    dc_en = dc; sample = 1; cen = ce;
    @(negedge clk);
    sample = 0; cen = 0;
  endtask

  task automatic wait_valid(output logic [15:0] v);
    bit ok = 0;
    v = 'x;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (snd_valid) begin ok = 1; v = snd; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL valid_timeout got none want pulse"); end
  endtask

  initial begin
    logic [15:0] v, prev;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    chk("reset_snd", snd, 16'd0);
    chk("reset_valid", {15'd0, snd_valid}, 16'd0);
    repeat (10) @(negedge clk);
    pulse(255, 0, 0, 15, 0, 0, 0, 1); wait_valid(v); chk("bypass_a", v, 16'd7650);
    pulse(255, 255, 255, 15, 15, 15, 0, 0); repeat (10) @(negedge clk);
    pulse(255, 255, 255, 15, 15, 15, 0, 1); wait_valid(v); chk("bypass_full", v, 16'd22950);
    pulse(255, 255, 255, 0, 0, 0, 0, 1); wait_valid(v); chk("bypass_zero", v, 16'd0);
    pulse(100, 50, 200, 3, 7, 1, 0, 1); wait_valid(v); chk("bypass_mix", v, 16'd1700);
    @(negedge clk); #2 rst = 1; #1;
    chk("async_rst_snd", snd, 16'd0);
    chk("async_rst_valid", {15'd0, snd_valid}, 16'd0);
    @(negedge clk) rst = 0;
    repeat (5) @(negedge clk);
    pulse(255, 255, 255, 15, 15, 15, 1, 1); wait_valid(v); chk("dc_first_sat", v, 16'd32767);
`ifdef JT49_MIX_OVF_EN
    chk("ovf_set", {15'd0, ovf}, 16'd1);
    @(negedge clk) ovf_clr = 1;
    @(negedge clk) ovf_clr = 0;
    chk("ovf_clr", {15'd0, ovf}, 16'd0);
`endif
    @(negedge clk);
    A = 10; B = 0; C = 0; ga = 1; gb = 0; gc = 0; dc_en = 0; sample = 1; cen = 1;
    @(negedge clk) sample = 0;
    @(negedge clk) begin A = 200; ga = 15; sample = 1; cen = 1; end
    @(negedge clk) sample = 0;
    wait_valid(v); chk("busy_drop", v, 16'd20);
`ifdef JT49_MIX_OVF_EN
    chk("ovf_drop", {15'd0, ovf}, 16'd1);
    @(negedge clk) ovf_clr = 1;
    @(negedge clk) ovf_clr = 0;
    chk("ovf_drop_clr", {15'd0, ovf}, 16'd0);
`endif
    repeat (8) @(negedge clk);
    pulse(255, 255, 255, 15, 15, 15, 1, 1);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    repeat (10) @(negedge clk);
    pulse(255, 0, 0, 15, 0, 0, 1, 1); wait_valid(v); chk("avg_cleared", v, 16'd15300);
    repeat (10) @(negedge clk);
    prev = 16'd32767;
    for (int i = 0; i < 2048; i++) begin
      pulse(255, 255, 255, 15, 15, 15, 1, 1); wait_valid(v);
      checks++;
      if ($signed(v) > $signed(prev)) begin errors++; $display("FAIL non_increasing got %0d want <= %0d", $signed(v), $signed(prev)); end
      prev = v;
      repeat (9) @(negedge clk);
    end
    checks++;
    if ($signed(snd) > 32 || $signed(snd) < -32) begin errors++; $display("FAIL dc_settled got %0d want |x|<=32", snd); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
